ldl_rr_pri_v2: RTL and testbench

Class-of-service round-robin arbiter with a registered grant and a valid/ready output handshake. This is the successor to the v1 priority round-robin arbiter. New in v2: an independent round-robin pointer per class, a grant that holds until accepted, and per-requester aging that promotes starved requesters to the top class. It sits in front of shared resources such as egress ports, memory request muxes and DMA channels.

---
 rtl/ldl_rr_pkg.sv | 22 ++
 rtl/ldl_rr_pick.sv | 37 +++
 rtl/ldl_rr_pri_v2.sv | 117 +++++++++++
 tb/tb_ldl_rr_pri_v2.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ldl_rr_pkg.sv
// Shared types and helpers for the ldl_rr arbiter family.
// idx_t / cos_t are aliases at the default widths (BIN_WIDTH=3, COS_WIDTH=2).
package ldl_rr_pkg;

    typedef logic [2:0] idx_t;
    typedef logic [1:0] cos_t;

    localparam int OH_MAX = 256;

    // OR of the set bit positions; exact for a one-hot (or zero) input.
    function automatic logic [7:0] onehot_to_bin(input logic [OH_MAX-1:0] oh);
        logic [7:0] b;
        b = '0;
        for (int k = 0; k < OH_MAX; k++) begin
            if (oh[k]) begin
                b = b | 8'(k);
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/ldl_rr_pick.sv
// Combinational masked round-robin search: first set bit of i_cand strictly
// above i_ptr, wrapping to the lowest set bit when nothing lies above it.
module ldl_rr_pick
    import ldl_rr_pkg::*;
#(
    parameter int BIN_WIDTH = 3
) (
    input  logic [(1 << BIN_WIDTH)-1:0] i_cand,
    input  logic [BIN_WIDTH-1:0]        i_ptr,
    output logic [(1 << BIN_WIDTH)-1:0] o_onehot,
    output logic [BIN_WIDTH-1:0]        o_bin,
    output logic                        o_found
);

    localparam int N = 1 << BIN_WIDTH;

    logic [N-1:0] w_mask;
    logic [N-1:0] w_masked;
    logic [N-1:0] w_src;
    logic [N-1:0] w_onehot;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_mask
            assign w_mask[gi] = (BIN_WIDTH'(gi) > i_ptr);
        end
    endgenerate

    assign w_masked = i_cand & w_mask;
    assign w_src    = (|w_masked) ? w_masked : i_cand;
    // Two's-complement trick isolates the lowest set bit.
    assign w_onehot = w_src & (~w_src + N'(1));

    assign o_onehot = w_onehot;
    assign o_bin    = BIN_WIDTH'(onehot_to_bin(OH_MAX'(w_onehot)));
    assign o_found  = |i_cand;

endmodule

// File: rtl/ldl_rr_pri_v2.sv
// Class-of-service round-robin arbiter with per-class pointers, held grant and aging.
// Optional LDL_RR_PRI_V2_LOCK_EN adds a lock input that re-grants the current owner.
module ldl_rr_pri_v2
    import ldl_rr_pkg::*;
#(
    parameter int BIN_WIDTH = 3,
    parameter int COS_WIDTH = 2,
    parameter int AGE_WIDTH = 3,
    parameter int REQ_WIDTH = 1 << BIN_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
`ifdef LDL_RR_PRI_V2_LOCK_EN
    input  logic                           lock,
`endif
    input  logic [REQ_WIDTH-1:0]           req,
    input  logic [REQ_WIDTH*COS_WIDTH-1:0] cos,
    input  logic                           ready,
    output logic [REQ_WIDTH-1:0]           ack,
    output logic [BIN_WIDTH-1:0]           bin,
    output logic                           valid
);

    localparam int                   NUM_COS = 1 << COS_WIDTH;
    localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;

    logic                 r_valid;
    logic [REQ_WIDTH-1:0] r_ack;
    logic [BIN_WIDTH-1:0] r_bin;
    logic [BIN_WIDTH-1:0] r_ptr [NUM_COS];
    logic [AGE_WIDTH-1:0] r_age [REQ_WIDTH];

    logic [COS_WIDTH-1:0] w_eff [REQ_WIDTH];
    logic [COS_WIDTH-1:0] w_top;
    logic [REQ_WIDTH-1:0] w_cand;
    logic [REQ_WIDTH-1:0] w_onehot;
    logic [BIN_WIDTH-1:0] w_bin;
    logic                 w_found;
    logic                 w_accept;
    logic                 w_slot_free;
    logic                 w_lock_hold;

    generate
        for (genvar gi = 0; gi < REQ_WIDTH; gi++) begin : g_req
            // A fully aged requester is promoted to the top class.
            assign w_eff[gi]  = (r_age[gi] == AGE_MAX) ? COS_WIDTH'(NUM_COS - 1)
                                                       : cos[gi*COS_WIDTH +: COS_WIDTH];
            assign w_cand[gi] = req[gi] && (w_eff[gi] == w_top);
        end
    endgenerate

    always_comb begin
        w_top = '0;
        for (int i = 0; i < REQ_WIDTH; i++) begin
            if (req[i] && (w_eff[i] > w_top)) begin
                w_top = w_eff[i];
            end
        end
    end

    ldl_rr_pick #(
        .BIN_WIDTH (BIN_WIDTH)
    ) u_pick (
        .i_cand   (w_cand),
        .i_ptr    (r_ptr[w_top]),
        .o_onehot (w_onehot),
        .o_bin    (w_bin),
        .o_found  (w_found)
    );

    assign w_accept    = r_valid && ready;
    assign w_slot_free = !r_valid || ready;

`ifdef LDL_RR_PRI_V2_LOCK_EN
    assign w_lock_hold = w_accept && lock && req[r_bin];
`else
    assign w_lock_hold = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_ack   <= '0;
            r_bin   <= '0;
            for (int c = 0; c < NUM_COS; c++) begin
                r_ptr[c] <= BIN_WIDTH'(REQ_WIDTH - 1);
            end
        end else if (w_slot_free && !w_lock_hold) begin
            r_valid <= w_found;
            r_ack   <= w_onehot;
            r_bin   <= w_bin;
            if (w_found) begin
                r_ptr[w_top] <= w_bin;
            end
        end
    end

    // Ages move only on an accepted grant; an idle requester always restarts at zero.
    always_ff @(posedge clk) begin
        for (int i = 0; i < REQ_WIDTH; i++) begin
            if (!rst || !req[i]) begin
                r_age[i] <= '0;
            end else if (w_accept && !w_lock_hold) begin
                if (r_bin == BIN_WIDTH'(i)) begin
                    r_age[i] <= '0;
                end else if (r_age[i] != AGE_MAX) begin
                    r_age[i] <= r_age[i] + AGE_WIDTH'(1);
                end
            end
        end
    end

    assign ack   = r_ack;
    assign bin   = r_bin;
    assign valid = r_valid;

endmodule

// File: tb/tb_ldl_rr_pri_v2.sv
// Directed bench for ldl_rr_pri_v2 with 4 requesters, 4 classes and AGE_MAX=3.
module tb_ldl_rr_pri_v2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [7:0] cos;
    logic       ready;
    logic [3:0] ack;
    logic [1:0] bin;
    logic       valid;
`ifdef LDL_RR_PRI_V2_LOCK_EN
    logic       lock;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ldl_rr_pri_v2 #(
        .BIN_WIDTH (2),
        .COS_WIDTH (2),
        .AGE_WIDTH (2)
    ) dut (
        .clk   (clk),
        .rst   (rst),
`ifdef LDL_RR_PRI_V2_LOCK_EN
        .lock  (lock),
`endif
        .req   (req),
        .cos   (cos),
        .ready (ready),
        .ack   (ack),
        .bin   (bin),
        .valid (valid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic gnt(input string tag, input int exp_bin);
        $display("[TB] %s valid=%0b bin=%0d ack=%b (want bin %0d)", tag, valid, bin, ack, exp_bin);
        chk({tag, ".valid"}, 32'(valid), 32'd1);
        chk({tag, ".bin"},   32'(bin),   32'(exp_bin));
        chk({tag, ".ack"},   32'(ack),   32'(1 << exp_bin));
    endtask

    task automatic idle(input string tag);
        $display("[TB] %s valid=%0b bin=%0d ack=%b (want idle)", tag, valid, bin, ack);
        chk({tag, ".valid"}, 32'(valid), 32'd0);
        chk({tag, ".ack"},   32'(ack),   32'd0);
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        req   = 4'b0000;
        ready = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        int s2[7];
        int s4[7];
        int s5[6];
        s2 = '{0, 2, 0, 2, 3, 0, 1};
        s4 = '{1, 2, 1, 2, 0, 1, 2};
        s5 = '{0, 2, 1, 3, 0, 2};

        rst   = 1'b0;
        req   = 4'b0000;
        cos   = 8'h00;
        ready = 1'b0;
`ifdef LDL_RR_PRI_V2_LOCK_EN
        lock  = 1'b0;
`endif

        // 1: reset state, then fair rotation in class 0
        tick();
        tick();
        idle("s1.reset");
        chk("s1.reset.bin", 32'(bin), 32'd0);
        rst   = 1'b1;
        req   = 4'b1111;
        ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            gnt($sformatf("s1.rr%0d", k), k);
        end

        // 2: class priority with aged requesters joining class 3
        do_reset();
        req   = 4'b1111;
        cos   = {2'd1, 2'd3, 2'd0, 2'd3};
        ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            gnt($sformatf("s2.g%0d", k), s2[k]);
        end

        // 3: grant held while ready=0, even after req drops
        do_reset();
        cos = 8'h00;
        req = 4'b0010;
        tick();
        gnt("s3.load", 1);
        for (int k = 0; k < 5; k++) begin
            if (k == 1) req = 4'b0000;
            tick();
            gnt($sformatf("s3.hold%0d", k), 1);
        end
        req   = 4'b1001;
        ready = 1'b1;
        tick();
        gnt("s3.next", 3);
        tick();
        gnt("s3.wrap", 0);
        req = 4'b0000;
        tick();
        idle("s3.none");

        // 4: aging promotes class-0 requester 0
        do_reset();
        req   = 4'b0111;
        cos   = {2'd0, 2'd3, 2'd3, 2'd0};
        ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            gnt($sformatf("s4.g%0d", k), s4[k]);
        end

        // 5: independent pointers for class 3 (0,1) and class 1 (2,3)
        do_reset();
        cos   = {2'd1, 2'd1, 2'd3, 2'd3};
        ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            req = (k % 2 == 0) ? 4'b0011 : 4'b1100;
            tick();
            gnt($sformatf("s5.g%0d", k), s5[k]);
        end

        // 6: reset in the middle of a held grant
        do_reset();
        cos = 8'h00;
        req = 4'b0100;
        tick();
        gnt("s6.load", 2);
        tick();
        gnt("s6.hold", 2);
        rst = 1'b0;
        req = 4'b1111;
        tick();
        idle("s6.rst");
        chk("s6.rst.bin", 32'(bin), 32'd0);
        rst   = 1'b1;
        ready = 1'b1;
        tick();
        gnt("s6.after", 0);

`ifdef LDL_RR_PRI_V2_LOCK_EN
        // lock: requester 2 re-granted while held, then normal rotation resumes
        do_reset();
        req   = 4'b0100;
        ready = 1'b1;
        tick();
        gnt("lk.load", 2);
        req  = 4'b1111;
        lock = 1'b1;
        tick();
        gnt("lk.hold0", 2);
        tick();
        gnt("lk.hold1", 2);
        lock = 1'b0;
        tick();
        gnt("lk.free", 3);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
